// File: rtl/sfr_uart_pkg.sv
// Shared SFR addresses, SCON bit positions and FSM encodings for the SFR-mapped UART.
package sfr_uart_pkg;

    localparam logic [7:0] SFR_SCON_ADDR = 8'h98;
    localparam logic [7:0] SFR_SBUF_ADDR = 8'h99;

    localparam int SCON_RI  = 0;
    localparam int SCON_TI  = 1;
    localparam int SCON_FE  = 2;
    localparam int SCON_OVR = 3;
    localparam int SCON_REN = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sfr_uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, byte / framing-error pulses.
//   state    | meaning
//   RX_IDLE  | waiting for a synchronized falling edge with REN set
//   RX_START | counting to mid start bit, rejecting glitches
//   RX_DATA  | sampling 8 data bits mid-bit, LSB first
//   RX_STOP  | sampling the stop bit, reporting byte or framing error
module sfr_uart_rx
    import sfr_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       ren,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync;
    logic          rx_s;
    logic          rx_prev;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign rx_s    = sync[1];
    assign rx_byte = shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], rxd};
            rx_prev <= rx_s;
        end
    end

    // REN only gates the start of a frame; a frame in flight always completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RX_IDLE;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shift       <= 8'h00;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (ren && rx_prev && !rx_s) begin
                        state <= RX_START;
                        cnt   <= HALF_LAST;
                    end
                end
                RX_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s) begin
                        state <= RX_IDLE;
                    end else begin
                        state   <= RX_DATA;
                        cnt     <= BIT_LAST;
                        bit_idx <= 3'd0;
                    end
                end
                RX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift <= {rx_s, shift[7:1]};
                        cnt   <= BIT_LAST;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= RX_IDLE;
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sfr_uart.sv
// SFR-mapped UART: SCON/SBUF register file, TX FSM, and the receiver sub-module.
//   state    | meaning
//   TX_IDLE  | line high, waiting for an SBUF write
//   TX_START | driving the start bit (0)
//   TX_DATA  | shifting 8 data bits out, LSB first
//   TX_STOP  | driving the stop bit (1); TI set as it ends
module sfr_uart
    import sfr_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sfr_rd_en,
    input  logic [7:0] sfr_rd_addr,
    output logic [7:0] sfr_rd_byte,
    input  logic       sfr_wr_en,
    input  logic [7:0] sfr_wr_addr,
    input  logic [7:0] sfr_wr_byte,
    output logic       uart_txd,
    input  logic       uart_rxd,
    output logic       tx_busy,
    output logic       irq
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    logic          ri, ti, fe, ovr, ren;
    logic          ri_n, ti_n, fe_n, ovr_n, ren_n;
    logic [7:0]    sbuf_rx;
    logic [7:0]    scon_rd;
    logic          wr_scon, wr_sbuf;
    logic [7:0]    rx_byte;
    logic          rx_valid, rx_ferr;
    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;
    logic          tx_done;

    sfr_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rxd         (uart_rxd),
        .ren         (ren),
        .rx_byte     (rx_byte),
        .byte_valid  (rx_valid),
        .frame_error (rx_ferr)
    );

    assign wr_scon = sfr_wr_en && (sfr_wr_addr == SFR_SCON_ADDR);
    assign wr_sbuf = sfr_wr_en && (sfr_wr_addr == SFR_SBUF_ADDR);
    assign tx_done = (tx_state == TX_STOP) && (tx_cnt == '0);

    // Software write applied first so a same-cycle hardware set overrides it.
    always_comb begin
        ri_n  = ri;
        ti_n  = ti;
        fe_n  = fe;
        ovr_n = ovr;
        ren_n = ren;
        if (wr_scon) begin
            ri_n  = sfr_wr_byte[SCON_RI];
            ti_n  = sfr_wr_byte[SCON_TI];
            fe_n  = sfr_wr_byte[SCON_FE];
            ovr_n = sfr_wr_byte[SCON_OVR];
            ren_n = sfr_wr_byte[SCON_REN];
        end
        if (rx_valid && !ri) ri_n = 1'b1;
        if (rx_valid && ri)  ovr_n = 1'b1;
        if (rx_ferr)         fe_n = 1'b1;
        if (tx_done)         ti_n = 1'b1;
    end

    always_comb begin
        scon_rd           = 8'h00;
        scon_rd[SCON_RI]  = ri;
        scon_rd[SCON_TI]  = ti;
        scon_rd[SCON_FE]  = fe;
        scon_rd[SCON_OVR] = ovr;
        scon_rd[SCON_REN] = ren;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ri          <= 1'b0;
            ti          <= 1'b0;
            fe          <= 1'b0;
            ovr         <= 1'b0;
            ren         <= 1'b0;
            sbuf_rx     <= 8'h00;
            irq         <= 1'b0;
            sfr_rd_byte <= 8'h00;
        end else begin
            ri  <= ri_n;
            ti  <= ti_n;
            fe  <= fe_n;
            ovr <= ovr_n;
            ren <= ren_n;
            irq <= ri_n | ti_n;
            if (rx_valid && !ri) sbuf_rx <= rx_byte;
            if (sfr_rd_en) begin
                if (sfr_rd_addr == SFR_SCON_ADDR)      sfr_rd_byte <= scon_rd;
                else if (sfr_rd_addr == SFR_SBUF_ADDR) sfr_rd_byte <= sbuf_rx;
                else                                   sfr_rd_byte <= 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= 3'd0;
            tx_shift <= 8'h00;
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (wr_sbuf) begin
                        tx_state <= TX_START;
                        tx_shift <= sfr_wr_byte;
                        tx_cnt   <= BIT_LAST;
                        uart_txd <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= BIT_LAST;
                        tx_idx   <= 3'd0;
                        uart_txd <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end
                end
                TX_DATA: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        tx_cnt <= BIT_LAST;
                        if (tx_idx == 3'd7) begin
                            tx_state <= TX_STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            tx_idx   <= tx_idx + 3'd1;
                            uart_txd <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        tx_state <= TX_IDLE;
                        tx_busy  <= 1'b0;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfr_uart.sv
// Bench for sfr_uart at 4 clocks per bit: frame-level reference model checked every cycle,
// plus directed SFR reads with literal expected values.
module tb_sfr_uart;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sfr_rd_en = 1'b0;
    logic [7:0] sfr_rd_addr = 8'h00;
    logic [7:0] sfr_rd_byte;
    logic       sfr_wr_en = 1'b0;
    logic [7:0] sfr_wr_addr = 8'h00;
    logic [7:0] sfr_wr_byte = 8'h00;
    logic       uart_txd;
    logic       uart_rxd = 1'b1;
    logic       tx_busy;
    logic       irq;

    int n_checks = 0;
    int n_errors = 0;

    sfr_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .sfr_rd_en   (sfr_rd_en),
        .sfr_rd_addr (sfr_rd_addr),
        .sfr_rd_byte (sfr_rd_byte),
        .sfr_wr_en   (sfr_wr_en),
        .sfr_wr_addr (sfr_wr_addr),
        .sfr_wr_byte (sfr_wr_byte),
        .uart_txd    (uart_txd),
        .uart_rxd    (uart_rxd),
        .tx_busy     (tx_busy),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a TX frame is ten bits each held CPB cycles; RX effects applied per frame.
    bit         m_ri, m_ti, m_fe, m_ovr, m_ren, m_busy;
    int         m_tcnt;
    logic [9:0] m_frame;
    logic [7:0] m_sbuf, m_rd;
    bit         rx_win = 1'b0;

    function automatic logic [7:0] m_scon();
        return {3'b000, m_ren, m_ovr, m_fe, m_ti, m_ri};
    endfunction

    task automatic model_reset();
        m_ri = 0; m_ti = 0; m_fe = 0; m_ovr = 0; m_ren = 0; m_busy = 0;
        m_tcnt = 0; m_frame = '1; m_sbuf = 8'h00; m_rd = 8'h00;
    endtask

    task automatic model_edge();
        bit done;
        done = 0;
        if (!rst) begin
            model_reset();
            return;
        end
        if (sfr_rd_en)
            m_rd = (sfr_rd_addr == 8'h98) ? m_scon() : (sfr_rd_addr == 8'h99) ? m_sbuf : 8'h00;
        if (m_busy) begin
            m_tcnt++;
            if (m_tcnt == 10 * CPB) begin
                m_busy = 0;
                done = 1;
            end
        end else if (sfr_wr_en && sfr_wr_addr == 8'h99) begin
            m_busy = 1;
            m_tcnt = 0;
            m_frame = {1'b1, sfr_wr_byte, 1'b0};
        end
        if (sfr_wr_en && sfr_wr_addr == 8'h98)
            {m_ren, m_ovr, m_fe, m_ti, m_ri} = sfr_wr_byte[4:0];
        if (done) m_ti = 1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        chk("uart_txd", {7'b0, uart_txd}, {7'b0, m_busy ? m_frame[m_tcnt / CPB] : 1'b1});
        chk("tx_busy", {7'b0, tx_busy}, {7'b0, m_busy});
        chk("sfr_rd_byte", sfr_rd_byte, m_rd);
        if (!rx_win) chk("irq", {7'b0, irq}, {7'b0, m_ri | m_ti});
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        sfr_wr_en = 1; sfr_wr_addr = a; sfr_wr_byte = d;
        cyc();
        sfr_wr_en = 0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        sfr_rd_en = 1; sfr_rd_addr = a;
        cyc();
        sfr_rd_en = 0;
        chk(name, sfr_rd_byte, exp);
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop, input bit clr_ren);
        logic [9:0] f;
        bit ren0;
        f = {stop, b, 1'b0};
        ren0 = m_ren;
        rx_win = 1;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            for (int k = 0; k < CPB; k++) begin
                if (clr_ren && i == 4 && k == 0) begin
                    sfr_wr_en = 1; sfr_wr_addr = 8'h98;
                    sfr_wr_byte = {3'b000, 1'b0, m_ovr, m_fe, m_ti, m_ri};
                end
                cyc();
                sfr_wr_en = 0;
            end
        end
        uart_rxd = 1;
        repeat (6) cyc();
        if (ren0) begin
            if (!stop)      m_fe = 1;
            else if (!m_ri) begin m_ri = 1; m_sbuf = b; end
            else            m_ovr = 1;
        end
        rx_win = 0;
    endtask

    logic [9:0] pat_a5;

    initial begin
        pat_a5 = 10'b1101001010;
        model_reset();
        repeat (3) cyc();
        chk("reset_txd", {7'b0, uart_txd}, 8'h01);
        chk("reset_busy", {7'b0, tx_busy}, 8'h00);
        chk("reset_irq", {7'b0, irq}, 8'h00);
        chk("reset_rd", sfr_rd_byte, 8'h00);
        rst = 1;
        cyc();
        rd_chk("scon_after_reset", 8'h98, 8'h00);
        rd_chk("unmapped_read", 8'h40, 8'h00);

        // TX 0xA5 with an ignored 0x3C write mid-frame
        wr(8'h99, 8'hA5);
        for (int j = 0; j < 10 * CPB; j++) begin
            if (j % CPB == 2) chk("a5_line_bit", {7'b0, uart_txd}, {7'b0, pat_a5[j / CPB]});
            if (j == 17) begin
                sfr_wr_en = 1; sfr_wr_addr = 8'h99; sfr_wr_byte = 8'h3C;
            end
            cyc();
            sfr_wr_en = 0;
        end
        chk("a5_end_irq", {7'b0, irq}, 8'h01);
        chk("a5_end_busy", {7'b0, tx_busy}, 8'h00);
        repeat (4) cyc();
        rd_chk("scon_ti", 8'h98, 8'h02);

        // RX: valid byte, overrun, framing error, glitch
        wr(8'h98, 8'h10);
        rx_frame(8'h5A, 1, 0);
        rd_chk("sbuf_5a", 8'h99, 8'h5A);
        rd_chk("scon_ri", 8'h98, 8'h11);
        rx_frame(8'h11, 1, 0);
        rd_chk("scon_ovr", 8'h98, 8'h19);
        rd_chk("sbuf_kept", 8'h99, 8'h5A);
        wr(8'h98, 8'h10);
        rx_frame(8'h77, 0, 0);
        rd_chk("scon_fe", 8'h98, 8'h14);
        wr(8'h98, 8'h10);
        uart_rxd = 0;
        cyc();
        uart_rxd = 1;
        repeat (12) cyc();
        rd_chk("scon_glitch", 8'h98, 8'h10);

        // TI set on the same edge as a software clear of TI
        wr(8'h99, 8'h81);
        repeat (10 * CPB - 1) cyc();
        wr(8'h98, 8'h10);
        rd_chk("scon_set_wins", 8'h98, 8'h12);

        // Simultaneous TX and RX
        wr(8'h98, 8'h10);
        wr(8'h99, 8'hC3);
        rx_frame(8'h96, 1, 0);
        rd_chk("sbuf_96", 8'h99, 8'h96);
        rd_chk("scon_both", 8'h98, 8'h13);

        // REN cleared mid-frame: frame still completes
        wr(8'h98, 8'h10);
        rx_frame(8'h3E, 1, 1);
        rd_chk("scon_ren_clr", 8'h98, 8'h01);
        rd_chk("sbuf_3e", 8'h99, 8'h3E);

        // Reset during data bit 3 of a TX frame
        wr(8'h99, 8'h00);
        repeat (18) cyc();
        chk("pre_reset_txd", {7'b0, uart_txd}, 8'h00);
        rst = 0;
        model_reset();
        #1;
        chk("rst_txd", {7'b0, uart_txd}, 8'h01);
        chk("rst_busy", {7'b0, tx_busy}, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_rd", sfr_rd_byte, 8'h00);
        repeat (2) cyc();
        rst = 1;
        repeat (2) cyc();
        rd_chk("post_rst_unmapped", 8'h40, 8'h00);
        rd_chk("post_rst_scon", 8'h98, 8'h00);
        repeat (CPB * 12) cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sfr_uart.md
SFR_UART -- requirements
Module: sfr_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per UART bit (legal range 4..65535).
REQ-002 clk  input  1  core clock, same clock as the CPU SFR bus.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 sfr_rd_en  input  1  SFR read strobe from the CPU.
REQ-005 sfr_rd_addr  input  8  SFR read address.
REQ-006 sfr_rd_byte  output  8  registered SFR read data.
REQ-007 sfr_wr_en  input  1  SFR write strobe from the CPU.
REQ-008 sfr_wr_addr  input  8  SFR write address.
REQ-009 sfr_wr_byte  input  8  SFR write data.
REQ-010 uart_txd  output  1  serial transmit line, idle high.
REQ-011 uart_rxd  input  1  serial receive line, asynchronous to clk.
REQ-012 tx_busy  output  1  high while a transmit frame is in progress.
REQ-013 irq  output  1  registered OR of RI and TI.

Function
REQ-014 SCON shall be at 0x98: bit0 RI, bit1 TI, bit2 FE (framing error), bit3 OVR (overrun), bit4 REN (receive enable), bits7:5 read 0.
REQ-015 SBUF shall be at 0x99: a write loads the TX shifter; a read returns the last received byte.
REQ-016 A read shall return data on sfr_rd_byte in the cycle after sfr_rd_en; with sfr_rd_en low, sfr_rd_byte shall hold its value.
REQ-017 A read of any other address shall return 0x00.
REQ-018 A write to SCON shall load REN, RI, TI, FE and OVR from the written byte (software clears flags by writing 0).
REQ-019 If a hardware flag set and a software clear of the same flag occur in the same cycle, the set shall win.
REQ-020 A write to SBUF while TX is idle shall start a frame on the next cycle; a write while tx_busy is high shall be ignored.
REQ-021 TX FSM states: IDLE, START, DATA, STOP; each bit shall last exactly CLKS_PER_BIT cycles.
REQ-022 The TX frame shall be one start bit (0), 8 data bits LSB first, and one stop bit (1).
REQ-023 TI shall be set, and tx_busy shall fall, on the cycle the stop bit ends; the FSM shall then return to IDLE.
REQ-024 uart_rxd shall pass through a 2-flop synchronizer before use.
REQ-025 RX FSM states: IDLE, START, DATA, STOP; it shall leave IDLE only on a synchronized falling edge while REN=1.
REQ-026 The start bit shall be sampled at CLKS_PER_BIT/2; if it reads 1, the FSM shall return to IDLE with no flag change.
REQ-027 Data bits shall be sampled mid-bit, LSB first, at intervals of CLKS_PER_BIT.
REQ-028 A stop bit sampled as 0 shall set FE, discard the byte, and return the FSM to IDLE.
REQ-029 On a valid stop bit with RI=0, the byte shall load SBUF and RI shall be set.
REQ-030 On a valid stop bit with RI=1, SBUF shall be left unchanged and OVR shall be set.
REQ-031 Clearing REN mid-frame shall not abort the frame in progress.
REQ-032 TX and RX shall operate fully independently, including simultaneously.

Reset
REQ-033 While rst=0: uart_txd=1, tx_busy=0, irq=0, sfr_rd_byte=0x00, SCON=0x00, SBUF=0x00, both FSMs in IDLE, counters 0, synchronizer flops 1.
REQ-034 Reset asserted mid-frame shall abort the frame immediately; no flag shall be set.

Structure
REQ-035 A shared package shall hold SFR_SCON_ADDR=8'h98, SFR_SBUF_ADDR=8'h99, the SCON bit-position constants, and the RX/TX state encodings.
REQ-036 The receiver shall be a sub-module named sfr_uart_rx (synchronizer, RX FSM, bit counter), reporting byte, byte_valid and frame_error to the top level.
REQ-037 The top level shall contain the SFR decode, the SCON/SBUF registers, and the TX FSM.

Verification (CLKS_PER_BIT=4)
REQ-038 Write 0x99<-0x A5 -> uart_txd shows 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; TI=1 and irq=1 at the end of the 40th cycle.
REQ-039 Second SBUF write (0x3C) while tx_busy=1 -> ignored; line carries 0xA5 only.
REQ-040 REN=1, drive frame 0x5A on uart_rxd -> RI=1; read 0x99 returns 0x5A one cycle after sfr_rd_en.
REQ-041 Second frame 0x11 received without clearing RI -> OVR=1 and SBUF still 0x5A.
REQ-042 Frame with stop bit 0 -> FE=1, RI unchanged; a 1-cycle glitch low on uart_rxd -> no flags change.
REQ-043 rst pulsed low during DATA bit 3 of TX -> uart_txd=1, tx_busy=0, TI=0 immediately; read of 0x40 -> 0x00.
